brownout_monitor: RTL



---
 rtl/brownout_monitor.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/brownout_monitor.sv
// brownout_monitor: supply brownout detector fed by an ADC sample stream.
// Trip threshold and drop-rate limit come from supply_vol/min_vol. Slow sags
// are debounced, fast collapses trip at once, and release waits through a
// hysteresis plus hold-off window.
// Optional build macro BOD_EVENT_CNT_EN enables the brownout entry counter;
// without it event_cnt is tied to zero.
module brownout_monitor #(
   parameter int DATA_W      = 8,
   parameter int RATE_SHIFT  = 3,
   parameter int DEBOUNCE    = 4,
   parameter int HYST        = 2,
   parameter int HOLD_CYCLES = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] adc_in,
   input  logic [DATA_W-1:0] supply_vol,
   input  logic [DATA_W-1:0] min_vol,
   output logic              brownout,
   output logic              warn,
   output logic [1:0]        state,
   output logic [DATA_W-1:0] drop_rate,
   output logic [7:0]        event_cnt
);

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'd0,
      ST_WARN     = 2'd1,
      ST_BROWNOUT = 2'd2,
      ST_RECOVER  = 2'd3
   } state_t;

   localparam int CNT_W  = (DEBOUNCE    < 1) ? 1 : $clog2(DEBOUNCE + 1);
   localparam int HOLD_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

   // Midpoint of two codes, summed one bit wider so it cannot overflow.
   function automatic logic [DATA_W-1:0] mid_code(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      logic [DATA_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[DATA_W:1];
   endfunction

   // Add a small offset, clamping at full scale instead of wrapping.
   function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W:0]   inc);
      logic [DATA_W:0] sum;
      sum = {1'b0, a} + inc;
      return sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
   endfunction

   // Allowed per-sample drop; an inverted supply/min pair gives no margin.
   function automatic logic [DATA_W-1:0] rate_limit(input logic [DATA_W-1:0] sup,
                                                    input logic [DATA_W-1:0] mn);
      logic [DATA_W-1:0] diff;
      diff = sup - mn;
      return (sup >= mn) ? (diff >> RATE_SHIFT) : '0;
   endfunction

   logic [DATA_W-1:0] thr_p1, rate_lim_p1, rec_thr_p1;
   logic [DATA_W-1:0] prev_q;
   logic              prev_valid_q;
   logic [DATA_W-1:0] drop;
   logic              below, fast_trip;
   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;

   // Stage p1: thresholds registered from the current supply/min codes.
   always_ff @(posedge clk) begin
      if (rst) begin
         thr_p1      <= '0;
         rate_lim_p1 <= '0;
         rec_thr_p1  <= '0;
      end else begin
         thr_p1      <= mid_code(supply_vol, min_vol);
         rate_lim_p1 <= rate_limit(supply_vol, min_vol);
         rec_thr_p1  <= sat_add(mid_code(supply_vol, min_vol), (DATA_W+1)'(HYST));
      end
   end

   // Sample-to-sample drop against the previous valid sample; rises count as 0.
   always_comb begin
      drop = '0;
      if (prev_valid_q && (prev_q > adc_in))
         drop = prev_q - adc_in;
      below     = (adc_in < thr_p1);
      fast_trip = below && (drop > rate_lim_p1);
   end

   // Remember the last valid sample and publish its drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         prev_q       <= '0;
         prev_valid_q <= 1'b0;
         drop_rate    <= '0;
      end else if (sample_valid) begin
         prev_q       <= adc_in;
         prev_valid_q <= 1'b1;
         drop_rate    <= drop;
      end
   end

   // Next-state logic: sample-driven except the hold-off count in RECOVER.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      case (state_q)
         ST_NORMAL: begin
            if (sample_valid && below) begin
               if (fast_trip || (DEBOUNCE <= 1)) begin
                  state_d = ST_BROWNOUT;
                  cnt_d   = '0;
               end else begin
                  state_d = ST_WARN;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         ST_WARN: begin
            if (sample_valid) begin
               if (!below) begin
                  state_d = ST_NORMAL;
                  cnt_d   = '0;
               end else if (fast_trip || ((int'(cnt_q) + 1) >= DEBOUNCE)) begin
                  state_d = ST_BROWNOUT;
                  cnt_d   = '0;
               end else if (cnt_q != {CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_BROWNOUT: begin
            if (sample_valid && (adc_in >= rec_thr_p1)) begin
               state_d = ST_RECOVER;
               hold_d  = '0;
            end
         end
         ST_RECOVER: begin
            if (sample_valid && (adc_in < rec_thr_p1)) begin
               state_d = ST_BROWNOUT;
               hold_d  = '0;
            end else if (int'(hold_q) >= (HOLD_CYCLES - 1)) begin
               state_d = ST_NORMAL;
               hold_d  = '0;
            end else if (hold_q != {HOLD_W{1'b1}}) begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = ST_NORMAL;
            cnt_d   = '0;
            hold_d  = '0;
         end
      endcase
   end

   // State register with outputs registered from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_NORMAL;
         cnt_q    <= '0;
         hold_q   <= '0;
         brownout <= 1'b0;
         warn     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hold_q   <= hold_d;
         brownout <= (state_d == ST_BROWNOUT) || (state_d == ST_RECOVER);
         warn     <= (state_d == ST_WARN);
      end
   end

   assign state = state_q;

`ifdef BOD_EVENT_CNT_EN
   logic       enter_bo;
   logic [7:0] event_cnt_q;

   assign enter_bo = (state_d == ST_BROWNOUT) &&
                     ((state_q == ST_NORMAL) || (state_q == ST_WARN));

   // Count fresh brownout entries; re-entry from RECOVER is the same event.
   always_ff @(posedge clk) begin
      if (rst)
         event_cnt_q <= '0;
      else if (enter_bo && (event_cnt_q != 8'hFF))
         event_cnt_q <= event_cnt_q + 8'd1;
   end

   assign event_cnt = event_cnt_q;
`else
   assign event_cnt = '0;
`endif

endmodule
